point_loader: RTL and testbench

Writer-side front end for the k-means point memory. It accepts a stream of (x, y) data points over a valid/ready handshake and packs each into the 31-bit point word {x[13:0], y[13:0], cluster[2:0]}. It writes the words to consecutive memory addresses starting at 0, then signals completion. It is the producer for the memory that the cluster-assignment and sum-accumulation stages read, and it runs before the first assignment pass.

---
 rtl/point_loader_if.sv | 15 +
 rtl/point_loader.sv | 94 +++++++++
 tb/tb_point_loader.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/point_loader_if.sv
// Point stream handshake between a point source and the loader.
interface point_loader_if;
   logic        pt_valid;
   logic        pt_ready;
   logic [13:0] pt_x;
   logic [13:0] pt_y;
   logic        pt_last;

   // Source side: presents points, observes ready.
   modport master (output pt_valid, output pt_x, output pt_y, output pt_last,
                   input  pt_ready);
   // Loader side: consumes points, drives ready.
   modport slave  (input  pt_valid, input  pt_x, input  pt_y, input  pt_last,
                   output pt_ready);
endinterface

// File: rtl/point_loader.sv
// Writer-side front end for the k-means point memory: packs incoming (x, y)
// points into {x, y, tag} words and writes them to addresses 0, 1, 2, ...
module point_loader #(
   parameter int unsigned DEPTH     = 1001,
   parameter int unsigned COORD_MAX = 10000,
   parameter logic [2:0]  INIT_TAG  = 3'd7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   point_loader_if.slave pt,
   output logic        mem_en,
   output logic [9:0]  mem_adr,
   output logic [30:0] mem_din,
   output logic        mem_wen,
   output logic        mem_ren,
   output logic        busy,
   output logic        load_done,
   output logic [9:0]  point_count,
   output logic        range_err
);

   localparam logic [13:0] CMAX     = 14'(COORD_MAX);
   localparam logic [9:0]  LAST_IDX = 10'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

   state_t      state_q, state_d;
   logic        wr_vld;
   logic        xfer;
   logic        final_pt;
   logic        start_ok;
   logic        clamped;
   logic [13:0] cx, cy;

   assign pt.pt_ready = (state_q == LOAD);
   assign xfer        = pt.pt_valid && pt.pt_ready;
   // The DEPTH-th transfer ends the load even without pt_last; point_count
   // still holds the index of the point being transferred here.
   assign final_pt    = xfer && (pt.pt_last || point_count == LAST_IDX);
   assign start_ok    = start && (state_q == IDLE || state_q == DONE);

   assign cx      = (pt.pt_x > CMAX) ? CMAX : pt.pt_x;
   assign cy      = (pt.pt_y > CMAX) ? CMAX : pt.pt_y;
   assign clamped = (cx != pt.pt_x) || (cy != pt.pt_y);

   assign mem_en    = wr_vld;
   assign mem_wen   = wr_vld;
   assign mem_ren   = 1'b0;
   assign busy      = (state_q == LOAD) || (state_q == FLUSH);
   assign load_done = (state_q == DONE);

   // Next-state logic; FLUSH covers the cycle in which the last write lands.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)    state_d = LOAD;
         LOAD:    if (final_pt) state_d = FLUSH;
         FLUSH:                 state_d = DONE;
         DONE:    if (start)    state_d = LOAD;
         default:               state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Write stage, point counter and sticky clamp flag. A reset drops any
   // write still sitting in the stage; memory itself is never cleared.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_vld      <= 1'b0;
         mem_adr     <= '0;
         mem_din     <= '0;
         point_count <= '0;
         range_err   <= 1'b0;
      end else begin
         wr_vld <= xfer;
         if (start_ok) begin
            point_count <= '0;
            range_err   <= 1'b0;
         end else if (xfer) begin
            mem_adr     <= point_count;
            mem_din     <= {cx, cy, INIT_TAG};
            point_count <= point_count + 10'd1;
            if (clamped) range_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_point_loader.sv
// Randomized scoreboard bench for point_loader.
module tb_point_loader;
   localparam int DEPTH = 1001;
   localparam int CMAX  = 10000;

   logic        clk = 1'b0;
   logic        rst, start;
   logic        mem_en, mem_wen, mem_ren, busy, load_done, range_err;
   logic [9:0]  mem_adr, point_count;
   logic [30:0] mem_din;

   always #5 clk = ~clk;

   point_loader_if pif();

   point_loader #(.DEPTH(DEPTH), .COORD_MAX(CMAX), .INIT_TAG(3'd7)) dut (
      .clk(clk), .rst(rst), .start(start), .pt(pif.slave),
      .mem_en(mem_en), .mem_adr(mem_adr), .mem_din(mem_din),
      .mem_wen(mem_wen), .mem_ren(mem_ren), .busy(busy),
      .load_done(load_done), .point_count(point_count), .range_err(range_err)
   );

   typedef struct {int cyc; int adr; int din;} wr_t;
   wr_t exp_q[$];

   int checks = 0, failures = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   // Reference model: phase 0 idle, 1 loading, 2 flushing, 3 done.
   int mph = 0, cnt = 0;
   bit rerr = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   function automatic int clampv(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   // Monitor: every write strobe must match the oldest expected write.
   always @(negedge clk) begin
      wr_t e;
      if (chk_en) begin
         check("mem_ren_low", 32'(mem_ren), 0);
         check("mem_en_eq_wen", 32'(mem_en), 32'(mem_wen));
         if (mem_wen === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_write: adr %0d din 0x%0h expected no write at cycle %0d",
                        mem_adr, mem_din, cyc);
            end else begin
               e = exp_q.pop_front();
               check("wr_cycle", cyc, e.cyc);
               check("wr_adr", 32'(mem_adr), e.adr);
               check("wr_din", 32'(mem_din), e.din);
            end
         end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            checks++; failures++;
            $display("FAIL missing_write: no write seen, expected adr %0d at cycle %0d", e.adr, e.cyc);
         end
      end
   end

   // One clock of stimulus: drive, check status against model, advance model.
   task automatic step(input bit r, input bit s, input bit v,
                       input int x, input int y, input bit l);
      wr_t e;
      rst = r; start = s;
      pif.pt_valid = v; pif.pt_x = 14'(x); pif.pt_y = 14'(y); pif.pt_last = l;
      @(negedge clk);
      if (chk_en) begin
         check("pt_ready",    32'(pif.pt_ready), (mph == 1) ? 1 : 0);
         check("busy",        32'(busy),         (mph == 1 || mph == 2) ? 1 : 0);
         check("load_done",   32'(load_done),    (mph == 3) ? 1 : 0);
         check("point_count", 32'(point_count),  cnt);
         check("range_err",   32'(range_err),    32'(rerr));
      end
      if (r) begin
         mph = 0; cnt = 0; rerr = 1'b0;
      end else begin
         case (mph)
            0, 3: if (s) begin mph = 1; cnt = 0; rerr = 1'b0; end
            1: if (v) begin
                  e.cyc = cyc + 1;
                  e.adr = cnt;
                  e.din = (clampv(x) << 17) | (clampv(y) << 3) | 7;
                  exp_q.push_back(e);
                  if (clampv(x) != x || clampv(y) != y) rerr = 1'b1;
                  cnt++;
                  if (l || cnt == DEPTH) mph = 2;
               end
            2: mph = 3;
            default: mph = 0;
         endcase
      end
      @(posedge clk); #1;
   endtask

   function automatic int rcoord();
      return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 16383))
                                         : int'($urandom_range(0, CMAX));
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, rcoord(), rcoord(), 0);
   endtask

   task automatic go();
      step(0, 1, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0;
      pif.pt_valid = 1'b0; pif.pt_x = '0; pif.pt_y = '0; pif.pt_last = 1'b0;
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      chk_en = 1'b1;
      check("rst_mem_adr", 32'(mem_adr), 0);
      check("rst_mem_din", 32'(mem_din), 0);
      idle(2);

      // Three points back to back, third is last.
      go();
      step(0, 0, 1, 1, 2, 0);
      step(0, 0, 1, 100, 200, 0);
      step(0, 0, 1, 10000, 0, 1);
      idle(3);
      check("three_count", 32'(point_count), 3);
      check("three_rerr", 32'(range_err), 0);

      // Clamping sets range_err; the next start clears it.
      go();
      step(0, 0, 1, 16383, 10001, 1);
      idle(3);
      check("clamp_rerr", 32'(range_err), 1);
      go();
      check("clamp_rerr_cleared", 32'(range_err), 0);
      step(0, 0, 1, 5, 6, 1);
      idle(3);

      // Gapped valid: one on, two off, five points.
      go();
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 1, rcoord(), rcoord(), i == 4);
         step(0, 0, 0, rcoord(), rcoord(), 0);
         step(0, 0, 0, rcoord(), rcoord(), 0);
      end
      idle(2);
      check("gap_count", 32'(point_count), 5);

      // Reset in the middle of a load, then a fresh two-point load.
      go();
      for (int i = 0; i < 4; i++) step(0, 0, 1, rcoord(), rcoord(), 0);
      step(1, 1, 1, rcoord(), rcoord(), 0);
      check("midrst_adr", 32'(mem_adr), 0);
      check("midrst_din", 32'(mem_din), 0);
      check("midrst_busy", 32'(busy), 0);
      go();
      step(0, 0, 1, rcoord(), rcoord(), 0);
      step(0, 0, 1, rcoord(), rcoord(), 1);
      idle(3);
      check("midrst_count", 32'(point_count), 2);

      // Start during LOAD is ignored.
      go();
      step(0, 0, 1, rcoord(), rcoord(), 0);
      step(0, 0, 1, rcoord(), rcoord(), 0);
      step(0, 1, 1, rcoord(), rcoord(), 0);
      step(0, 0, 1, rcoord(), rcoord(), 1);
      idle(3);
      check("start_in_load_count", 32'(point_count), 4);

      // Full-depth load with no pt_last, then stray valids.
      go();
      for (int g = 0; g < 5000 && mph == 1; g++)
         step(0, 0, $urandom_range(0, 4) != 0, rcoord(), rcoord(), 0);
      for (int i = 0; i < 6; i++) step(0, 0, 1, rcoord(), rcoord(), 0);
      check("full_count", 32'(point_count), 1001);
      check("full_last_adr", 32'(mem_adr), 1000);

      // Random loads of random length with random gaps.
      for (int k = 0; k < 20; k++) begin
         int n;
         n = $urandom_range(1, 12);
         go();
         for (int i = 0; i < n; i++) begin
            for (int gp = $urandom_range(0, 2); gp > 0; gp--)
               step(0, 0, 0, rcoord(), rcoord(), 0);
            step(0, 0, 1, rcoord(), rcoord(), i == n - 1);
         end
         idle($urandom_range(2, 4));
         check("rand_count", 32'(point_count), n);
      end

      idle(3);
      check("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
